// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: burst reader for the weight ROM, streaming words through a 2-entry buffer
module weight_fetch_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic                  head_q, head_d, tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pop, last_rd;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_comb begin
    w_valid    = occ_q != 2'd0;
    w_data     = buf_q[head_q];
    pop        = w_valid & w_ready;
    w_last     = w_valid && tx_cnt_q == cnt_q - CNT_WIDTH'(1);
    rom_addr   = base_q + rd_cnt_q[ADDR_WIDTH-1:0];
    // a read is only issued if its word is guaranteed a buffer slot on arrival
    rom_en     = state_q == FETCH && (3'(occ_q) + 3'(inflight_q) < 3'd2 + 3'(pop));
    last_rd    = rom_en && rd_cnt_q == cnt_q - CNT_WIDTH'(1);
    base_d     = base_q;
    cnt_d      = cnt_q;
    rd_cnt_d   = rd_cnt_q + CNT_WIDTH'(rom_en);
    tx_cnt_d   = tx_cnt_q + CNT_WIDTH'(pop);
    inflight_d = rom_en;
    buf_d      = buf_q;
    buf_d[tail_q] = inflight_q ? rom_data : buf_q[tail_q];
    tail_d     = tail_q ^ inflight_q;
    head_d     = head_q ^ pop;
    occ_d      = occ_q + 2'(inflight_q) - 2'(pop);
    state_d    = state_q;
    if (state_q == IDLE && start) begin
      base_d   = base_addr;
      cnt_d    = count;
      rd_cnt_d = '0;
      tx_cnt_d = '0;
      state_d  = count == '0 ? DONE : FETCH;
    end
    else if (state_q == FETCH)
      state_d = last_rd ? DRAIN : FETCH;
    else if (state_q == DRAIN)
      state_d = (w_last && pop) ? DONE : DRAIN;
    else if (state_q == DONE)
      state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
    end
  end
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb_weight_fetch_ctrl: directed and randomized bursts against a queue-based stream model
module tb_weight_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  base_addr = '0;
  logic [2:0]  count = '0;
  logic        busy, done, rom_en, w_valid, w_last;
  logic        w_ready = 1'b1;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data, w_data;
  logic [15:0] mem [4];
  int          passed = 0, total = 0;
  bit          rnd_mode = 0;

  weight_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a burst is the list of words it must deliver; a word can be offered
  // once its read has been issued at least two cycles earlier.
  int          ph = 0, m_base = 0, m_cnt = 0, reads = 0, xfers = 0, landed;
  bit          prev_en = 0, exp_valid, exp_pop;
  logic [15:0] q [$];

  always @(negedge clk) begin
    if (rst) begin
      ph = 0; q.delete(); reads = 0; xfers = 0; prev_en = 0;
    end else begin
      landed    = reads - int'(prev_en);
      exp_valid = ph == 1 && landed > xfers;
      exp_pop   = exp_valid && w_ready;
      chk("busy", busy, ph != 0);
      chk("done", done, ph == 2);
      chk("w_valid", w_valid, exp_valid);
      chk("rom_en", rom_en, ph == 1 && reads < m_cnt && reads - xfers - int'(exp_pop) < 2);
      if (rom_en) chk("rom_addr", rom_addr, (m_base + reads) % 4);
      if (w_valid && q.size() > 0) begin
        chk("w_data", w_data, q[0]);
        chk("w_last", w_last, q.size() == 1);
      end else chk("w_last_idle", w_last, 0);
      if (ph == 2) ph = 0;
      else if (ph == 0 && start) begin
        m_base = base_addr; m_cnt = count; reads = 0; xfers = 0; prev_en = 0;
        for (int i = 0; i < m_cnt; i++) q.push_back(mem[(m_base + i) % 4]);
        ph = m_cnt == 0 ? 2 : 1;
      end else if (ph == 1) begin
        reads += int'(rom_en);
        prev_en = rom_en;
        if (w_valid && w_ready && q.size() > 0) begin
          xfers++;
          void'(q.pop_front());
          if (q.size() == 0) ph = 2;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_mode) w_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_burst(input logic [1:0] b, input logic [2:0] c);
    start = 1'b1; base_addr = b; count = c;
    cyc();
    start = 1'b0; base_addr = 2'($urandom); count = 3'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (!busy) return;
      cyc();
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [1:0]  aq [$];
    logic [15:0] dq [$];
    logic [15:0] e;
    logic [1:0]  ea [3];
    logic [15:0] ed [3];
    int          n;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    #3;
    chk("rst_busy", busy, 0); chk("rst_rom_en", rom_en, 0); chk("rst_w_valid", w_valid, 0);
    chk("rst_w_data", w_data, 0); chk("rst_rom_addr", rom_addr, 0);
    cyc(); cyc(); rst = 1'b0; cyc();
    start_burst(2'd0, 3'd4);
    for (int c = 1; c <= 7; c++) begin
      e = 16'(c - 2) * 16'h1111;
      chk($sformatf("t1_busy_c%0d", c), busy, 1);
      chk($sformatf("t1_done_c%0d", c), done, c == 7);
      chk($sformatf("t1_rom_en_c%0d", c), rom_en, c >= 1 && c <= 4);
      chk($sformatf("t1_w_valid_c%0d", c), w_valid, c >= 3 && c <= 6);
      chk($sformatf("t1_w_last_c%0d", c), w_last, c == 6);
      if (c >= 3 && c <= 6) chk($sformatf("t1_w_data_c%0d", c), w_data, e);
      cyc();
    end
    chk("t1_busy_after", busy, 0);
    start_burst(2'd3, 3'd3);
    for (int i = 0; i < 20 && busy; i++) begin
      if (rom_en) aq.push_back(rom_addr);
      if (w_valid && w_ready) dq.push_back(w_data);
      cyc();
    end
    ea = '{2'd3, 2'd0, 2'd1};
    ed = '{16'h4444, 16'h1111, 16'h2222};
    chk("t2_nreads", aq.size(), 3);
    chk("t2_nwords", dq.size(), 3);
    for (int i = 0; i < 3 && i < aq.size(); i++) chk($sformatf("t2_addr%0d", i), aq[i], ea[i]);
    for (int i = 0; i < 3 && i < dq.size(); i++) chk($sformatf("t2_word%0d", i), dq[i], ed[i]);
    w_ready = 1'b0;
    start_burst(2'd0, 3'd4);
    n = 0;
    for (int c = 1; c <= 9; c++) begin
      n += int'(rom_en);
      cyc();
    end
    chk("t3_reads_stalled", n, 2);
    chk("t3_held_data", w_data, 16'h1111);
    w_ready = 1'b1;
    wait_idle();
    start_burst(2'd1, 3'd0);
    chk("t4_done", done, 1);
    chk("t4_rom_en", rom_en, 0);
    cyc();
    chk("t4_idle", busy, 0);
    start_burst(2'd0, 3'd4);
    cyc();
    start = 1'b1; base_addr = 2'd2; count = 3'd1;
    cyc();
    start = 1'b0;
    wait_idle();
    start_burst(2'd0, 3'd4);
    for (int c = 1; c <= 4; c++) cyc();
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0); chk("t6_done", done, 0); chk("t6_rom_en", rom_en, 0);
    chk("t6_w_valid", w_valid, 0); chk("t6_w_last", w_last, 0);
    chk("t6_w_data", w_data, 0); chk("t6_rom_addr", rom_addr, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    start_burst(2'd2, 3'd4);
    wait_idle();
    rnd_mode = 1;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
      start_burst(2'($urandom), 3'($urandom_range(0, 4)));
      if ($urandom_range(0, 2) == 0) begin
        cyc();
        start = 1'b1; base_addr = 2'($urandom); count = 3'($urandom);
        cyc();
        start = 1'b0;
      end
      wait_idle();
    end
    rnd_mode = 0;
    w_ready = 1'b1;
    cyc(); cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
